// File: rtl/pc_redirect_ctrl.sv
// PC redirect arbiter: branch/jump/load-use control for the PC, IF/ID and ID/EX registers.
// Optional PC_REDIRECT_STATS_EN adds saturating redirect/stall counters.
module pc_redirect_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump_req,
    input  logic [N-1:0] jump_target,
    input  logic         load_use_hazard,
    input  logic         imem_ready,
    output logic         pc_enable,
    output logic         jump,
    output logic [N-1:0] jump_address,
    output logic         if_id_enable,
    output logic         if_id_flush,
    output logic         id_ex_flush
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0]  redirect_count,
    output logic [31:0]  hazard_stall_count,
    output logic [31:0]  mem_stall_count
`endif
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           pend_valid_q, pend_valid_d;
    logic           pend_src_q, pend_src_d;
    logic [N-1:0]   pend_addr_q, pend_addr_d;

    logic           sel_valid;
    logic           sel_src;
    logic [N-1:0]   sel_addr;
    logic           hazard;
    logic           pc_en_raw;

    always_comb begin
        sel_valid = 1'b0;
        sel_src   = 1'b0;
        sel_addr  = '0;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    sel_valid = 1'b1;
                    sel_src   = 1'b1;
                    sel_addr  = branch_target;
                end else if (jump_req) begin
                    sel_valid = 1'b1;
                    sel_src   = 1'b0;
                    sel_addr  = jump_target;
                end
            end
            HOLD: begin
                sel_valid = pend_valid_q;
                sel_src   = pend_src_q;
                sel_addr  = pend_addr_q;
                // An EX branch is older than a held ID jump, so it takes over.
                if (branch_taken && !pend_src_q) begin
                    sel_src  = 1'b1;
                    sel_addr = branch_target;
                end
            end
            default: ;
        endcase
    end

    assign hazard    = load_use_hazard && !sel_valid;
    assign pc_en_raw = imem_ready && !hazard;

    always_comb begin
        pc_enable    = 1'b0;
        jump         = 1'b0;
        jump_address = '0;
        if_id_enable = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        if (!rst) begin
            pc_enable    = pc_en_raw;
            jump         = sel_valid;
            jump_address = sel_valid ? sel_addr : '0;
            if_id_enable = pc_en_raw;
            if_id_flush  = sel_valid && pc_en_raw;
            id_ex_flush  = (sel_valid && sel_src && pc_en_raw) || hazard;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_src_d   = pend_src_q;
        pend_addr_d  = pend_addr_q;
        case (state_q)
            RUN: begin
                if (sel_valid && !imem_ready) begin
                    state_d      = HOLD;
                    pend_valid_d = 1'b1;
                    pend_src_d   = sel_src;
                    pend_addr_d  = sel_addr;
                end
            end
            HOLD: begin
                if (imem_ready) begin
                    state_d      = RUN;
                    pend_valid_d = 1'b0;
                end else begin
                    pend_src_d  = sel_src;
                    pend_addr_d = sel_addr;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            pend_valid_q <= 1'b0;
            pend_src_q   <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_src_q   <= pend_src_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_count     <= '0;
            hazard_stall_count <= '0;
            mem_stall_count    <= '0;
        end else begin
            if (sel_valid && pc_en_raw && redirect_count != '1)
                redirect_count <= redirect_count + 32'd1;
            if (hazard && hazard_stall_count != '1)
                hazard_stall_count <= hazard_stall_count + 32'd1;
            if (!imem_ready && mem_stall_count != '1)
                mem_stall_count <= mem_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl: directed scenarios then random traffic against a pending-redirect model.
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump_req;
    logic [31:0] jump_target;
    logic        load_use_hazard;
    logic        imem_ready;
    logic        pc_enable;
    logic        jump;
    logic [31:0] jump_address;
    logic        if_id_enable;
    logic        if_id_flush;
    logic        id_ex_flush;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] redirect_count, hazard_stall_count, mem_stall_count;
    longint      m_rc, m_hc, m_mc;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference: a redirect that the PC has not yet accepted stays "owed" until delivered.
    bit          m_owed;
    bit          m_owed_ex;
    logic [31:0] m_owed_addr;
    bit          m_sel, m_sel_ex, m_haz, m_pe;
    logic [31:0] m_sel_addr;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_req(jump_req), .jump_target(jump_target),
        .load_use_hazard(load_use_hazard), .imem_ready(imem_ready),
        .pc_enable(pc_enable), .jump(jump), .jump_address(jump_address),
        .if_id_enable(if_id_enable), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush)
`ifdef PC_REDIRECT_STATS_EN
        , .redirect_count(redirect_count), .hazard_stall_count(hazard_stall_count),
        .mem_stall_count(mem_stall_count)
`endif
    );

    task automatic check(input string tag);
        logic [36:0] exp, obs;
        m_sel = 0; m_sel_ex = 0; m_sel_addr = '0;
        if (m_owed) begin
            m_sel = 1; m_sel_ex = m_owed_ex; m_sel_addr = m_owed_addr;
            if (branch_taken && !m_owed_ex) begin m_sel_ex = 1; m_sel_addr = branch_target; end
        end else if (branch_taken) begin
            m_sel = 1; m_sel_ex = 1; m_sel_addr = branch_target;
        end else if (jump_req) begin
            m_sel = 1; m_sel_ex = 0; m_sel_addr = jump_target;
        end
        m_haz = load_use_hazard && !m_sel;
        m_pe  = imem_ready && !m_haz;
        if (rst) exp = '0;
        else exp = {m_pe, m_sel, (m_sel ? m_sel_addr : 32'h0), m_pe, m_sel && m_pe,
                    (m_sel && m_sel_ex && m_pe) || m_haz};
        obs = {pc_enable, jump, jump_address, if_id_enable, if_id_flush, id_ex_flush};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got pe=%b j=%b a=%h ife=%b iff=%b ief=%b, want pe=%b j=%b a=%h ife=%b iff=%b ief=%b",
                   tag, obs[36], obs[35], obs[34:3], obs[2], obs[1], obs[0],
                   exp[36], exp[35], exp[34:3], exp[2], exp[1], exp[0]);
        end
`ifdef PC_REDIRECT_STATS_EN
        vectors++;
        assert ({redirect_count, hazard_stall_count, mem_stall_count} ===
                {m_rc[31:0], m_hc[31:0], m_mc[31:0]}) else begin
            miscompares++;
            $error("FAIL %s stats: got %0d/%0d/%0d want %0d/%0d/%0d", tag,
                   redirect_count, hazard_stall_count, mem_stall_count, m_rc, m_hc, m_mc);
        end
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_owed = 0;
`ifdef PC_REDIRECT_STATS_EN
            m_rc = 0; m_hc = 0; m_mc = 0;
`endif
        end else begin
            if (m_sel && !imem_ready) begin
                m_owed = 1; m_owed_ex = m_sel_ex; m_owed_addr = m_sel_addr;
            end else m_owed = 0;
`ifdef PC_REDIRECT_STATS_EN
            if (m_sel && m_pe && m_rc < 64'hFFFF_FFFF) m_rc++;
            if (m_haz && m_hc < 64'hFFFF_FFFF) m_hc++;
            if (!imem_ready && m_mc < 64'hFFFF_FFFF) m_mc++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic step(input bit r, input bit bt, input logic [31:0] bta, input bit jr,
                        input logic [31:0] jta, input bit lu, input bit ir, input string tag);
        rst = r; branch_taken = bt; branch_target = bta; jump_req = jr; jump_target = jta;
        load_use_hazard = lu; imem_ready = ir;
        #1 check(tag);
        advance();
    endtask

    initial begin
        m_owed = 0; m_owed_ex = 0; m_owed_addr = '0;
`ifdef PC_REDIRECT_STATS_EN
        m_rc = 0; m_hc = 0; m_mc = 0;
`endif
        step(1, 1, 32'h55, 1, 32'h66, 1, 1, "reset");
        step(1, 0, 0, 0, 0, 0, 1, "reset2");

        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1, "free_run");

        step(0, 1, 32'h40, 0, 0, 0, 1, "ex_branch");
        step(0, 0, 0, 0, 0, 0, 1, "ex_branch_after");
        step(0, 1, 32'h80, 1, 32'h20, 0, 1, "simultaneous");
        step(0, 0, 0, 0, 0, 0, 1, "simul_after");
        step(0, 0, 0, 0, 0, 1, 1, "load_use");
        step(0, 0, 0, 0, 0, 1, 0, "load_use_nomem");
        step(0, 1, 32'h44, 0, 0, 1, 1, "load_use_branch");
        step(0, 0, 0, 1, 32'h30, 1, 1, "load_use_jump");

        step(0, 0, 0, 1, 32'h10, 0, 0, "hold_c1");
        step(0, 1, 32'h99, 0, 0, 0, 0, "hold_c2");
        step(0, 0, 0, 1, 32'h77, 1, 0, "hold_c3");
        step(0, 0, 0, 0, 0, 0, 1, "hold_deliver");
        step(0, 0, 0, 0, 0, 0, 0, "hold_after");
        step(0, 0, 0, 0, 0, 0, 1, "hold_after2");

        step(0, 1, 32'hABCD_1234, 0, 0, 0, 0, "hold_ex");
        step(0, 1, 32'h1111_1111, 0, 0, 0, 0, "hold_ex_keep");
        step(0, 0, 0, 0, 0, 0, 1, "hold_ex_deliver");

        step(0, 0, 0, 1, 32'h5A, 0, 0, "pre_rst_hold");
        step(1, 0, 0, 0, 0, 0, 0, "rst_mid_hold");
        step(0, 0, 0, 0, 0, 0, 1, "after_rst");

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 2,
                 $urandom_range(99) < 20, $urandom,
                 $urandom_range(99) < 25, $urandom,
                 $urandom_range(99) < 20,
                 $urandom_range(99) < 60, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
